as_fifo_axis_out: RTL and testbench
===================================

AS_FIFO_AXIS_OUT -- requirements
Module: as_fifo_axis_out

Interface
REQ-001 Parameter WIDTH, default 45, SHALL be the FIFO word width; fields are [31:0] tdata, [35:32] tstrb, [39:36] tkeep, [41:40] tid, [43:42] tuser, [44] tlast.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of pkt_cnt and beat_cnt.
REQ-003 axis_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 axi_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  pull enable from the FIFO.
REQ-006 f_r_vld  input  1  FIFO read-side valid.
REQ-007 f_r_rdy  output  1  FIFO read-side ready, connects to the FIFO r_rdy input.
REQ-008 f_data  input  WIDTH  FIFO read data.
REQ-009 m_tvalid  output  1  AXI-Stream master valid.
REQ-010 m_tready  input  1  AXI-Stream master ready.
REQ-011 m_tdata/m_tstrb/m_tkeep/m_tid/m_tuser/m_tlast  output  32/4/4/2/2/1  AXI-Stream master payload.
REQ-012 pkt_cnt  output  CNT_W  count of completed packets.
REQ-013 beat_cnt  output  CNT_W  count of beats sent.
REQ-014 drop_cnt  output  8  count of dropped null words.
REQ-015 busy  output  1  asserted while the buffer holds at least one word.

Function
REQ-016 The block SHALL hold a 2-entry buffer: a head register driving m_* directly and a skid register behind it.
REQ-017 The FSM SHALL have three states: EMPTY (0 words), ONE (1 word) and TWO (2 words).
REQ-018 f_r_rdy SHALL be en & (state!=TWO), decoded from registers only, with no combinational path from m_tready or f_r_vld.
REQ-019 accept SHALL be f_r_vld & f_r_rdy, and pop SHALL be m_tvalid & m_tready.
REQ-020 A null word (f_data[39:36]==0 and f_data[44]==0) SHALL be accepted, not stored, and SHALL increment drop_cnt, saturating at 255.
REQ-021 store SHALL be accept & ~null.
REQ-022 FSM transitions SHALL be:
- EMPTY, store -> ONE (head<=word).
- ONE, store & ~pop -> TWO (skid<=word).
- ONE, pop & ~store -> EMPTY.
- ONE, store & pop -> ONE (head<=word).
- TWO, pop -> ONE (head<=skid).
- Otherwise the state SHALL hold.
REQ-023 In TWO no store SHALL occur, because f_r_rdy is 0.
REQ-024 Latency: a word stored in cycle N with the buffer EMPTY SHALL appear on m_* with m_tvalid=1 in cycle N+1.
REQ-025 m_tvalid SHALL be (state!=EMPTY).
REQ-026 m_* SHALL stay stable while m_tvalid & ~m_tready.
REQ-027 Word order SHALL match FIFO order exactly, with no duplication or loss other than null drops.
REQ-028 While en=0, no new words SHALL be accepted and buffered words SHALL still drain.
REQ-029 busy SHALL equal (state!=EMPTY).
REQ-030 beat_cnt SHALL increment on every pop and wrap modulo 2^CNT_W.
REQ-031 pkt_cnt SHALL increment on a pop with m_tlast=1 and wrap modulo 2^CNT_W.
REQ-032 A simultaneous store and pop SHALL keep the occupancy unchanged and SHALL update both counters in the same cycle.
REQ-033 A null word accepted in the same cycle as a pop SHALL change only the pop path and drop_cnt.

Reset
REQ-034 While axi_reset_n=0, state SHALL be EMPTY and every output SHALL be 0 (m_*, f_r_rdy, busy, pkt_cnt, beat_cnt, drop_cnt).
REQ-035 After reset release, f_r_rdy SHALL follow en from the first clock edge.
REQ-036 Assertion of axi_reset_n mid-packet SHALL discard all buffered words immediately (asynchronously); no partial beat SHALL be emitted after release.

Verification
REQ-037 en=1, m_tready=1, 4 words with tdata 1..4 and tlast on word 4 -> 4 beats in order, each 1 cycle after accept; pkt_cnt=1, beat_cnt=4.
REQ-038 m_tready=0, 3 words offered -> 2 accepted, f_r_rdy=0 in TWO, m_* holds word 1; m_tready=1 -> words 1, 2, 3 emitted in order.
REQ-039 Null word (tkeep=0, tlast=0) between words A and B -> output A then B only; drop_cnt=1; a word with tkeep=0 and tlast=1 SHALL be forwarded.
REQ-040 State ONE, store and pop in the same cycle for 10 cycles -> stays in ONE, beat_cnt+10, no bubble.
REQ-041 en dropped while in TWO -> both words drain, then busy=0, f_r_rdy=0; beat_cnt 0xFFFF plus one pop -> 0x0000.
REQ-042 Reset asserted in TWO -> m_tvalid=0 immediately (asynchronously), all counters 0.

Source files
------------

// File: rtl/as_fifo_axis_out.sv
// as_fifo_axis_out
// Pulls words from a FIFO read port and presents them as an AXI-Stream master.
// A two-entry buffer (head + skid) lets f_r_rdy be decoded from registers
// only, so neither m_tready nor f_r_vld reaches f_r_rdy combinationally.
// Null words (tkeep==0 and tlast==0) are consumed from the FIFO and counted
// in drop_cnt, but never reach the stream.
module as_fifo_axis_out #(
  parameter int WIDTH = 45,
  parameter int CNT_W = 16
) (
  input  logic             axis_clk,
  input  logic             axi_reset_n,
  input  logic             en,
  input  logic             f_r_vld,
  output logic             f_r_rdy,
  input  logic [WIDTH-1:0] f_data,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [31:0]      m_tdata,
  output logic [3:0]       m_tstrb,
  output logic [3:0]       m_tkeep,
  output logic [1:0]       m_tid,
  output logic [1:0]       m_tuser,
  output logic             m_tlast,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  // Buffer occupancy: number of words held in head/skid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             run_q;

  logic             accept;
  logic             pop;
  logic             is_null;
  logic             store;
  logic             head_load;
  logic             head_from_skid;
  logic             skid_load;

  // Handshakes. run_q keeps f_r_rdy low while in reset and opens it at the
  // first clock edge after release; from then on f_r_rdy follows en.
  assign f_r_rdy  = run_q & en & (state != ST_TWO);
  assign m_tvalid = (state != ST_EMPTY);
  assign busy     = (state != ST_EMPTY);
  assign accept   = f_r_vld & f_r_rdy;
  assign pop      = m_tvalid & m_tready;
  assign is_null  = (f_data[39:36] == 4'd0) & ~f_data[44];
  assign store    = accept & ~is_null;

  // The head register drives the stream payload directly.
  assign m_tdata  = head_q[31:0];
  assign m_tstrb  = head_q[35:32];
  assign m_tkeep  = head_q[39:36];
  assign m_tid    = head_q[41:40];
  assign m_tuser  = head_q[43:42];
  assign m_tlast  = head_q[44];

  // Next-state and buffer load selects for the occupancy FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_nxt      = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (store) begin
          state_nxt = ST_ONE;
          head_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (store && !pop) begin
          state_nxt = ST_TWO;
          skid_load = 1'b1;
        end else if (pop && !store) begin
          state_nxt = ST_EMPTY;
        end else if (store && pop) begin
          head_load = 1'b1;
        end
      end
      ST_TWO: begin
        // f_r_rdy is low here, so only a pop can move the FSM.
        if (pop) begin
          state_nxt      = ST_ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy state and the post-reset ready enable.
  always_ff @(posedge axis_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state <= ST_EMPTY;
      run_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  // Head and skid data registers.
  always_ff @(posedge axis_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      // NOTE: data registers are reset here only because the payload outputs
      // must read zero during reset; plain datapath storage normally is not.
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_load) begin
        head_q <= f_data;
      end else if (head_from_skid) begin
        head_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= f_data;
      end
    end
  end

  // Beat and packet counters wrap; the null-drop counter saturates.
  always_ff @(posedge axis_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (m_tlast) begin
          pkt_cnt <= pkt_cnt + 1'b1;
        end
      end
      if (accept && is_null && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_as_fifo_axis_out.sv
// Self-checking bench for as_fifo_axis_out. A negedge monitor keeps a
// scoreboard queue of stored words, pushed on accept and popped/compared on
// each output beat, plus reference counters and occupancy.
module tb_as_fifo_axis_out;

  logic        axis_clk;
  logic        axi_reset_n;
  logic        en;
  logic        f_r_vld;
  logic        f_r_rdy;
  logic [44:0] f_data;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic [3:0]  m_tkeep;
  logic [1:0]  m_tid;
  logic [1:0]  m_tuser;
  logic        m_tlast;
  logic [15:0] pkt_cnt;
  logic [15:0] beat_cnt;
  logic [7:0]  drop_cnt;
  logic        busy;

  as_fifo_axis_out #(.WIDTH(45), .CNT_W(16)) dut (
    .axis_clk   (axis_clk),
    .axi_reset_n(axi_reset_n),
    .en         (en),
    .f_r_vld    (f_r_vld),
    .f_r_rdy    (f_r_rdy),
    .f_data     (f_data),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tstrb    (m_tstrb),
    .m_tkeep    (m_tkeep),
    .m_tid      (m_tid),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .pkt_cnt    (pkt_cnt),
    .beat_cnt   (beat_cnt),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [44:0] exp_q[$];
  logic [15:0] exp_beat = '0;
  logic [15:0] exp_pkt  = '0;
  logic [7:0]  exp_drop = '0;
  int          cyc_since_rst = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [44:0] mk(input logic [31:0] d, input logic [3:0] keep,
                                     input logic last);
    return {last, d[3:2], d[1:0], keep, keep ^ 4'h5, d};
  endfunction

  function automatic logic [44:0] obs();
    return {m_tlast, m_tuser, m_tid, m_tkeep, m_tstrb, m_tdata};
  endfunction

  // Scoreboard monitor, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge axis_clk) begin
    int occ;
    if (!axi_reset_n) begin
      exp_q.delete();
      exp_beat = '0;
      exp_pkt  = '0;
      exp_drop = '0;
      cyc_since_rst = 0;
      check("rst_outputs",
            {m_tvalid, f_r_rdy, busy, pkt_cnt, beat_cnt, drop_cnt},
            64'd0);
      check("rst_payload", obs(), 64'd0);
    end else begin
      occ = exp_q.size();
      check("m_tvalid", m_tvalid, occ != 0);
      check("busy", busy, occ != 0);
      check("f_r_rdy", f_r_rdy, en && (occ < 2) && (cyc_since_rst >= 1));
      if (occ != 0) check("payload", obs(), exp_q[0]);
      check("beat_cnt", beat_cnt, exp_beat);
      check("pkt_cnt", pkt_cnt, exp_pkt);
      check("drop_cnt", drop_cnt, exp_drop);
      if (m_tvalid && m_tready && occ != 0) begin
        if (exp_q[0][44]) exp_pkt = exp_pkt + 16'd1;
        exp_beat = exp_beat + 16'd1;
        void'(exp_q.pop_front());
      end
      if (f_r_vld && f_r_rdy) begin
        if (f_data[39:36] == 4'd0 && !f_data[44]) begin
          if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        end else begin
          exp_q.push_back(f_data);
        end
      end
      cyc_since_rst++;
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  // Present one word and hold it until the DUT accepts it.
  task automatic send_word(input logic [44:0] w);
    int n;
    f_r_vld = 1'b1;
    f_data  = w;
    n = 0;
    while (n < 1000) begin
      @(negedge axis_clk);
      if (f_r_rdy) break;
      n++;
    end
    if (n >= 1000) check("accept_timeout", 64'd0, 64'd1);
    tick();
    f_r_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 1000 && (busy || exp_q.size() != 0)) begin
      @(negedge axis_clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", 64'd0, 64'd1);
    tick();
  endtask

  initial begin
    axi_reset_n = 1'b0;
    en          = 1'b1;
    f_r_vld     = 1'b0;
    f_data      = '0;
    m_tready    = 1'b1;
    repeat (3) tick();
    axi_reset_n = 1'b1;
    check("rdy_before_edge", f_r_rdy, 1'b0);
    tick();
    check("rdy_after_edge", f_r_rdy, 1'b1);

    // Four-beat packet, streaming.
    for (int i = 1; i <= 4; i++) send_word(mk(i, 4'hF, i == 4));
    wait_idle();
    check("pkt4_pkt_cnt", pkt_cnt, 16'd1);
    check("pkt4_beat_cnt", beat_cnt, 16'd4);

    // Backpressure: two words fill the buffer, the third waits.
    m_tready = 1'b0;
    send_word(mk(32'h11, 4'hF, 1'b0));
    send_word(mk(32'h22, 4'hF, 1'b0));
    f_r_vld = 1'b1;
    f_data  = mk(32'h33, 4'hF, 1'b1);
    repeat (3) @(negedge axis_clk);
    check("bp_rdy_low", f_r_rdy, 1'b0);
    check("bp_head_hold", m_tdata, 32'h11);
    tick();
    m_tready = 1'b1;
    f_r_vld  = 1'b0;
    send_word(mk(32'h33, 4'hF, 1'b1));
    wait_idle();
    check("bp_beats", beat_cnt, 16'd7);

    // Null word between A and B is dropped; keep=0 with tlast is forwarded.
    send_word(mk(32'hA, 4'hF, 1'b0));
    send_word(mk(32'h0, 4'h0, 1'b0));
    send_word(mk(32'hB, 4'hF, 1'b0));
    send_word(mk(32'hC, 4'h0, 1'b1));
    wait_idle();
    check("null_drop_cnt", drop_cnt, 8'd1);
    check("null_beats", beat_cnt, 16'd10);

    // Store and pop in the same cycle for 10 cycles stays in ONE.
    send_word(mk(32'h100, 4'hF, 1'b0));
    begin
      logic [15:0] b0;
      b0 = beat_cnt;
      for (int i = 1; i <= 10; i++) send_word(mk(32'h100 + i, 4'hF, 1'b0));
      check("one_beat_delta", beat_cnt - b0, 16'd10);
      check("one_busy", busy, 1'b1);
    end
    wait_idle();

    // en dropped while in TWO: both words drain.
    m_tready = 1'b0;
    send_word(mk(32'h201, 4'hF, 1'b0));
    send_word(mk(32'h202, 4'hF, 1'b1));
    en       = 1'b0;
    m_tready = 1'b1;
    wait_idle();
    check("en0_busy", busy, 1'b0);
    check("en0_rdy", f_r_rdy, 1'b0);
    en = 1'b1;

    // drop_cnt saturates at 255.
    for (int i = 0; i < 300; i++) send_word(mk(i, 4'h0, 1'b0));
    wait_idle();
    check("drop_sat", drop_cnt, 8'hFF);

    // Reset asserted in TWO clears everything asynchronously.
    m_tready = 1'b0;
    send_word(mk(32'h301, 4'hF, 1'b0));
    send_word(mk(32'h302, 4'hF, 1'b0));
    axi_reset_n = 1'b0;
    #1;
    check("arst_tvalid", m_tvalid, 1'b0);
    check("arst_cnts", {pkt_cnt, beat_cnt, drop_cnt, busy}, 64'd0);
    repeat (2) tick();
    m_tready    = 1'b1;
    axi_reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_tvalid", m_tvalid, 1'b0);
    check("post_rst_beats", beat_cnt, 16'd0);

    // beat_cnt wraps from 0xFFFF to 0x0000.
    for (int i = 0; i < 65535; i++) send_word(mk(i, 4'hF, 1'b0));
    wait_idle();
    check("beat_ffff", beat_cnt, 16'hFFFF);
    send_word(mk(32'hDEAD, 4'hF, 1'b0));
    wait_idle();
    check("beat_wrap", beat_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
